// File: rtl/sd_wb_pkg.sv
// ---------------------------------------------------------------------------
// sd_wb_pkg
// Shared constants for the SD host controller Wishbone slave front-end:
//   - address decode values (command/status vs. data)
//   - slave FSM state encodings
//   - bit positions of the fields in the status word returned on adr 0 reads
// ---------------------------------------------------------------------------
package sd_wb_pkg;

  localparam logic ADR_CMD  = 1'b0;
  localparam logic ADR_DATA = 1'b1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  localparam int STAT_CMD_BIT      = 63;
  localparam int STAT_RSP_PEND_BIT = 62;
  localparam int STAT_RSP_LSB      = 0;

endpackage

// File: rtl/sd_wb_fifo.sv
// ---------------------------------------------------------------------------
// sd_wb_fifo
// Small synchronous FIFO used for the TX and RX data paths.
// Ports:
//   clock, reset : system clock, async active-high reset (empties the FIFO)
//   push, din    : write request and data (ignored while full)
//   pop          : read request (ignored while empty)
//   dout         : current head entry
//   full, empty  : registered status flags
// Pointers carry one extra wrap bit so full/empty are told apart by the MSB.
// ---------------------------------------------------------------------------
module sd_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Flags come straight from the registered pointers, so a pop in the same
  // cycle never makes room for a push into a full FIFO.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    dout     = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; entries are only visible once written.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/wishbone_slave_sd.sv
// ---------------------------------------------------------------------------
// wishbone_slave_sd
// Wishbone slave front-end of the SD host controller.
// Ports:
//   clock, reset             : system clock, async active-high reset
//   strobe_i, we_i, adr_i    : Wishbone request (adr 0 = cmd/status, 1 = data)
//   wb_data_i / wb_data_o    : write data in / read data out (held after ack)
//   ack_o                    : one-cycle transfer acknowledge
//   cmd_valid_o, cmd_data_o,
//   cmd_ready_i              : latched command word toward the command engine
//   rsp_valid_i, rsp_data_i  : SD response capture
//   tx_valid_o, tx_data_o,
//   tx_ready_i               : TX FIFO head toward the SD data path
//   rx_valid_i, rx_data_i,
//   rx_ready_o               : RX FIFO input from the SD data path
// ---------------------------------------------------------------------------
module wishbone_slave_sd
  import sd_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 64,
  parameter int RSP_W      = 48
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              strobe_i,
  input  logic              we_i,
  input  logic              adr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              ack_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              cmd_valid_o,
  output logic [DATA_W-1:0] cmd_data_o,
  input  logic              cmd_ready_i,
  input  logic              rsp_valid_i,
  input  logic [RSP_W-1:0]  rsp_data_i,
  output logic              tx_valid_o,
  output logic [DATA_W-1:0] tx_data_o,
  input  logic              tx_ready_i,
  input  logic              rx_valid_i,
  input  logic [DATA_W-1:0] rx_data_i,
  output logic              rx_ready_o
);

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [DATA_W-1:0] cmd_data_q, cmd_data_d;
  logic [RSP_W-1:0]  rsp_q, rsp_d;
  logic              rsp_pending_q, rsp_pending_d;

  logic              accept;
  logic [DATA_W-1:0] status_word;
  logic              tx_push, tx_pop, tx_full, tx_empty;
  logic              rx_push, rx_pop, rx_full, rx_empty;
  logic [DATA_W-1:0] rx_head;

  // A request is only evaluated in IDLE; if its resource is not ready the
  // slave simply stays in IDLE, which acts as a wait state for the master.
  always_comb begin
    accept = 1'b0;
    if (state_q == ST_IDLE && strobe_i) begin
      if (we_i) begin
        accept = (adr_i == ADR_CMD) ? !cmd_valid_q : !tx_full;
      end else begin
        accept = (adr_i == ADR_CMD) ? 1'b1 : !rx_empty;
      end
    end

    status_word                            = '0;
    status_word[STAT_CMD_BIT]              = cmd_valid_q;
    status_word[STAT_RSP_PEND_BIT]         = rsp_pending_q;
    status_word[STAT_RSP_LSB +: RSP_W]     = rsp_q;

    // ACK lasts exactly one cycle; acceptance only happens from IDLE.
    state_d = accept ? ST_ACK : ST_IDLE;

    wb_data_d = wb_data_q;
    if (accept && !we_i) begin
      wb_data_d = (adr_i == ADR_CMD) ? status_word : rx_head;
    end

    // The clear uses the registered valid, so a new command can only be
    // accepted on a later IDLE evaluation.
    cmd_valid_d = cmd_valid_q;
    cmd_data_d  = cmd_data_q;
    if (cmd_valid_q && cmd_ready_i) begin
      cmd_valid_d = 1'b0;
    end
    if (accept && we_i && adr_i == ADR_CMD) begin
      cmd_valid_d = 1'b1;
      cmd_data_d  = wb_data_i;
    end

    // A fresh response wins over the clear-on-read of the pending flag.
    rsp_d         = rsp_q;
    rsp_pending_d = rsp_pending_q;
    if (rsp_valid_i) begin
      rsp_d         = rsp_data_i;
      rsp_pending_d = 1'b1;
    end else if (accept && !we_i && adr_i == ADR_CMD) begin
      rsp_pending_d = 1'b0;
    end

    tx_push = accept && we_i && adr_i == ADR_DATA;
    tx_pop  = !tx_empty && tx_ready_i;
    rx_push = rx_valid_i && !rx_full;
    rx_pop  = accept && !we_i && adr_i == ADR_DATA;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      wb_data_q     <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_data_q    <= '0;
      rsp_q         <= '0;
      rsp_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wb_data_q     <= wb_data_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_data_q    <= cmd_data_d;
      rsp_q         <= rsp_d;
      rsp_pending_q <= rsp_pending_d;
    end
  end

  sd_wb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_tx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (wb_data_i),
    .dout  (tx_data_o),
    .full  (tx_full),
    .empty (tx_empty)
  );

  sd_wb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_rx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_data_i),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  assign ack_o       = (state_q == ST_ACK);
  assign wb_data_o   = wb_data_q;
  assign cmd_valid_o = cmd_valid_q;
  assign cmd_data_o  = cmd_data_q;
  assign tx_valid_o  = !tx_empty;
  assign rx_ready_o  = !rx_full;

endmodule

// File: tb/tb_wishbone_slave_sd.sv
// ---------------------------------------------------------------------------
// tb_wishbone_slave_sd
// Bench for wishbone_slave_sd: directed scenarios with literal expectations,
// then a long randomized run, all shadowed by a transaction-level model.
// ---------------------------------------------------------------------------
module tb_wishbone_slave_sd;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        strobe_i, we_i, adr_i;
  logic [63:0] wb_data_i;
  logic        ack_o;
  logic [63:0] wb_data_o;
  logic        cmd_valid_o;
  logic [63:0] cmd_data_o;
  logic        cmd_ready_i;
  logic        rsp_valid_i;
  logic [47:0] rsp_data_i;
  logic        tx_valid_o;
  logic [63:0] tx_data_o;
  logic        tx_ready_i;
  logic        rx_valid_i;
  logic [63:0] rx_data_i;
  logic        rx_ready_o;

  int checkCount = 0;
  int passCount  = 0;
  int acks;
  bit checkEnable = 1'b0;

  // Model state: what the slave must look like after each clock edge.
  bit          ackDue;
  logic [63:0] rdataExp;
  bit          cmdPending;
  logic [63:0] cmdWord;
  logic [47:0] rspWord;
  bit          rspPend;
  logic [63:0] txq[$];
  logic [63:0] rxq[$];

  wishbone_slave_sd dut (
    .clock       (clock),
    .reset       (reset),
    .strobe_i    (strobe_i),
    .we_i        (we_i),
    .adr_i       (adr_i),
    .wb_data_i   (wb_data_i),
    .ack_o       (ack_o),
    .wb_data_o   (wb_data_o),
    .cmd_valid_o (cmd_valid_o),
    .cmd_data_o  (cmd_data_o),
    .cmd_ready_i (cmd_ready_i),
    .rsp_valid_i (rsp_valid_i),
    .rsp_data_i  (rsp_data_i),
    .tx_valid_o  (tx_valid_o),
    .tx_data_o   (tx_data_o),
    .tx_ready_i  (tx_ready_i),
    .rx_valid_i  (rx_valid_i),
    .rx_data_i   (rx_data_i),
    .rx_ready_o  (rx_ready_o)
  );

  // Free-running 10-unit clock.
  always #5 clock = ~clock;

  // One comparison: count it, and report actual vs. required on a miss.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: actual %h required %h at %0t", name, actual, expected, $time);
  endtask

  // Drive the Wishbone request lines on the next falling edge.
  task automatic applyStimulus(input logic stb, input logic we, input logic adr,
                               input logic [63:0] data);
    @(negedge clock);
    strobe_i  = stb;
    we_i      = we;
    adr_i     = adr;
    wb_data_i = data;
  endtask

  // Everything the model holds goes back to its power-on view.
  task automatic modelReset();
    ackDue     = 1'b0;
    rdataExp   = '0;
    cmdPending = 1'b0;
    cmdWord    = '0;
    rspWord    = '0;
    rspPend    = 1'b0;
    txq.delete();
    rxq.delete();
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  // All decisions look at the state from before the edge.
  task automatic modelStep();
    int          txSize     = txq.size();
    int          rxSize     = rxq.size();
    bit          oldCmd     = cmdPending;
    bit          oldRspPend = rspPend;
    logic [47:0] oldRsp     = rspWord;
    bit          accepted   = 1'b0;
    if (!ackDue && strobe_i) begin
      if (we_i) accepted = adr_i ? (txSize < DEPTH) : !oldCmd;
      else      accepted = adr_i ? (rxSize > 0) : 1'b1;
    end
    if (txSize > 0 && tx_ready_i) void'(txq.pop_front());
    if (accepted && we_i && adr_i) txq.push_back(wb_data_i);
    if (accepted && !we_i) begin
      if (adr_i) rdataExp = rxq.pop_front();
      else       rdataExp = {oldCmd, oldRspPend, 14'b0, oldRsp};
    end
    if (rx_valid_i && rxSize < DEPTH) rxq.push_back(rx_data_i);
    if (oldCmd && cmd_ready_i) cmdPending = 1'b0;
    if (accepted && we_i && !adr_i) begin
      cmdPending = 1'b1;
      cmdWord    = wb_data_i;
    end
    if (rsp_valid_i) begin
      rspWord = rsp_data_i;
      rspPend = 1'b1;
    end else if (accepted && !we_i && !adr_i) begin
      rspPend = 1'b0;
    end
    ackDue = accepted;
  endtask

  // The model follows every rising edge outside reset.
  always @(posedge clock) begin
    if (!reset) modelStep();
  end

  // Every falling edge the visible outputs are held against the model.
  always @(negedge clock) begin
    if (!reset && checkEnable) begin
      checkOutput("m_ack", 64'(ack_o), 64'(ackDue));
      checkOutput("m_rdata", wb_data_o, rdataExp);
      checkOutput("m_cmd_valid", 64'(cmd_valid_o), 64'(cmdPending));
      checkOutput("m_cmd_data", cmd_data_o, cmdWord);
      checkOutput("m_tx_valid", 64'(tx_valid_o), 64'(txq.size() > 0));
      if (txq.size() > 0) checkOutput("m_tx_data", tx_data_o, txq[0]);
      checkOutput("m_rx_ready", 64'(rx_ready_o), 64'(rxq.size() < DEPTH));
    end
  end

  // Directed scenarios first, then randomized traffic.
  initial begin
    reset       = 1'b1;
    strobe_i    = 1'b0;
    we_i        = 1'b0;
    adr_i       = 1'b0;
    wb_data_i   = '0;
    cmd_ready_i = 1'b0;
    rsp_valid_i = 1'b0;
    rsp_data_i  = '0;
    tx_ready_i  = 1'b0;
    rx_valid_i  = 1'b0;
    rx_data_i   = '0;
    modelReset();
    checkEnable = 1'b1;

    // Reset state
    @(negedge clock);
    checkOutput("rst_ack", 64'(ack_o), 64'd0);
    checkOutput("rst_rdata", wb_data_o, 64'd0);
    checkOutput("rst_cmd_valid", 64'(cmd_valid_o), 64'd0);
    checkOutput("rst_tx_valid", 64'(tx_valid_o), 64'd0);
    checkOutput("rst_rx_ready", 64'(rx_ready_o), 64'd1);
    @(negedge clock);
    reset = 1'b0;

    // Command handshake: second write waits until the engine takes the first
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h11);
    @(posedge clock); #1;
    checkOutput("cmd1_ack", 64'(ack_o), 64'd1);
    checkOutput("cmd1_valid", 64'(cmd_valid_o), 64'd1);
    checkOutput("cmd1_data", cmd_data_o, 64'h11);
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h22);
    repeat (3) begin
      @(posedge clock); #1;
      checkOutput("cmd2_stall", 64'(ack_o), 64'd0);
    end
    @(negedge clock);
    cmd_ready_i = 1'b1;
    @(posedge clock); #1;
    checkOutput("cmd1_cleared", 64'(cmd_valid_o), 64'd0);
    checkOutput("cmd2_no_ack_on_clear", 64'(ack_o), 64'd0);
    @(posedge clock); #1;
    checkOutput("cmd2_ack", 64'(ack_o), 64'd1);
    checkOutput("cmd2_data", cmd_data_o, 64'h22);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);

    // TX full: four writes fit, the fifth waits for a pop
    applyStimulus(1'b1, 1'b1, 1'b1, 64'd1);
    acks = 0;
    repeat (12) begin
      @(posedge clock); #1;
      if (ack_o) begin
        acks++;
        applyStimulus(1'b1, 1'b1, 1'b1, 64'(acks + 1));
      end
    end
    checkOutput("tx_ack_count", 64'(acks), 64'd4);
    checkOutput("tx_head_first", tx_data_o, 64'd1);
    @(negedge clock);
    tx_ready_i = 1'b1;
    @(posedge clock); #1;
    checkOutput("tx_no_bypass", 64'(ack_o), 64'd0);
    checkOutput("tx_head_after_pop", tx_data_o, 64'd2);
    @(negedge clock);
    tx_ready_i = 1'b0;
    @(posedge clock); #1;
    checkOutput("tx_fifth_ack", 64'(ack_o), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
    for (int k = 2; k <= 5; k++) begin
      checkOutput("tx_order", tx_data_o, 64'(k));
      tx_ready_i = 1'b1;
      @(negedge clock);
    end
    tx_ready_i = 1'b0;
    checkOutput("tx_drained", 64'(tx_valid_o), 64'd0);

    // RX: a read waits on an empty FIFO, then overflow drops a word
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h0);
    repeat (3) begin
      @(posedge clock); #1;
      checkOutput("rx_empty_stall", 64'(ack_o), 64'd0);
    end
    @(negedge clock);
    rx_valid_i = 1'b1;
    rx_data_i  = 64'hA5;
    @(posedge clock); #1;
    checkOutput("rx_no_bypass", 64'(ack_o), 64'd0);
    @(negedge clock);
    rx_valid_i = 1'b0;
    @(posedge clock); #1;
    checkOutput("rx_a5_ack", 64'(ack_o), 64'd1);
    checkOutput("rx_a5_data", wb_data_o, 64'hA5);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
    rx_valid_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      rx_data_i = 64'h100 + 64'(k);
      @(negedge clock);
    end
    rx_valid_i = 1'b0;
    checkOutput("rx_full", 64'(rx_ready_o), 64'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h0);
    acks = 0;
    repeat (12) begin
      @(posedge clock); #1;
      if (ack_o) begin
        checkOutput("rx_read_data", wb_data_o, 64'h100 + 64'(acks));
        acks++;
      end
    end
    checkOutput("rx_fifth_dropped", 64'(acks), 64'd4);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);

    // Status word: pending flag shows once, then clears on read
    @(negedge clock);
    rsp_valid_i = 1'b1;
    rsp_data_i  = 48'h1234_5678_9ABC;
    @(negedge clock);
    rsp_valid_i = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
    @(posedge clock); #1;
    checkOutput("stat_first", wb_data_o, 64'h4000_1234_5678_9ABC);
    @(posedge clock);
    @(posedge clock); #1;
    checkOutput("stat_second", wb_data_o, 64'h0000_1234_5678_9ABC);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);

    // Response arriving on the same edge as a status read
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
    rsp_valid_i = 1'b1;
    rsp_data_i  = 48'hFEDC_BA98_7654;
    @(posedge clock); #1;
    checkOutput("stat_coincident_old", wb_data_o, 64'h0000_1234_5678_9ABC);
    @(negedge clock);
    rsp_valid_i = 1'b0;
    @(posedge clock);
    @(posedge clock); #1;
    checkOutput("stat_coincident_new", wb_data_o, 64'h4000_FEDC_BA98_7654);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);

    // Reset in the middle of an ACK clears everything without a clock edge
    cmd_ready_i = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 64'h7);
    @(posedge clock); #1;
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h9);
    @(posedge clock);
    @(posedge clock); #1;
    checkOutput("pre_reset_ack", 64'(ack_o), 64'd1);
    #2;
    reset = 1'b1;
    modelReset();
    #1;
    checkOutput("async_rst_ack", 64'(ack_o), 64'd0);
    checkOutput("async_rst_tx_valid", 64'(tx_valid_o), 64'd0);
    checkOutput("async_rst_cmd_valid", 64'(cmd_valid_o), 64'd0);
    checkOutput("async_rst_rdata", wb_data_o, 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
    @(negedge clock);
    reset = 1'b0;

    // Randomized traffic on every input, judged by the model
    for (int c = 0; c < 2000; c++) begin
      @(negedge clock);
      strobe_i    = ($urandom_range(0, 9) < 6);
      we_i        = 1'($urandom_range(0, 1));
      adr_i       = 1'($urandom_range(0, 1));
      wb_data_i   = {$urandom(), $urandom()};
      cmd_ready_i = ($urandom_range(0, 9) < 4);
      rsp_valid_i = ($urandom_range(0, 9) == 0);
      rsp_data_i  = 48'({$urandom(), $urandom()});
      tx_ready_i  = ($urandom_range(0, 9) < 4);
      rx_valid_i  = ($urandom_range(0, 9) < 4);
      rx_data_i   = {$urandom(), $urandom()};
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
    rsp_valid_i = 1'b0;
    rx_valid_i  = 1'b0;
    repeat (2) @(negedge clock);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/wishbone_slave_sd.md
Name: wishbone_slave_sd

Overview:
Wishbone slave front-end of the SD host controller, directly downstream of wishbone_master. It decodes the 1-bit address (command vs. data), latches command words for the SD command engine, and buffers data words in TX/RX FIFOs toward the SD data path. It returns ack and read data to the master.

Parameters:
FIFO_DEPTH, 4, entries per TX and RX FIFO; must be a power of two, minimum 2.
DATA_W, 64, Wishbone data width.
RSP_W, 48, SD response width.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
strobe_i  input  1  Wishbone strobe from master.
we_i  input  1  1 = write (to SD), 0 = read (from SD).
adr_i  input  1  0 = command/status, 1 = data.
wb_data_i  input  DATA_W  write data from master.
ack_o  output  1  single-cycle transfer acknowledge.
wb_data_o  output  DATA_W  read data to master; valid while ack_o=1.
cmd_valid_o  output  1  command word pending for SD command engine.
cmd_data_o  output  DATA_W  latched command word.
cmd_ready_i  input  1  command engine accepts cmd_data_o.
rsp_valid_i  input  1  one-cycle pulse: new SD response.
rsp_data_i  input  RSP_W  SD response.
tx_valid_o  output  1  TX FIFO not empty.
tx_data_o  output  DATA_W  TX FIFO head.
tx_ready_i  input  1  SD data path pops TX head.
rx_valid_i  input  1  SD data path pushes a word.
rx_data_i  input  DATA_W  word to push.
rx_ready_o  output  1  RX FIFO not full.

Behaviour:
- Reset (async, immediate): ack_o=0, wb_data_o=0, cmd_valid_o=0, cmd_data_o=0, rsp register and rsp_pending cleared, both FIFOs empty (tx_valid_o=0, rx_ready_o=1). FSM returns to IDLE. Any in-flight transfer is dropped with no ack.
- FSM states are IDLE and ACK. ACK always returns to IDLE after one cycle. ack_o=1 only in ACK, so the maximum rate is one transfer per 2 cycles. A strobe held high continuously produces repeated transfers.
- In IDLE with strobe_i=1, the transfer is accepted when its condition below is met. On acceptance the FSM goes to ACK, and the action takes effect on the same edge. If the condition is not met, the FSM stays in IDLE with no ack (wait state) until it is.
  - Write, adr 0: condition cmd_valid_o=0. Latch cmd_data_o=wb_data_i and set cmd_valid_o.
  - Write, adr 1: condition TX not full. Push wb_data_i.
  - Read, adr 0: always accepted. wb_data_o={cmd_valid_o, rsp_pending, 14'b0, rsp_q}. Clear rsp_pending.
  - Read, adr 1: condition RX not empty. wb_data_o=RX head, then pop.
- wb_data_o holds its value outside ACK. It is not cleared.
- cmd_valid_o clears on the edge where cmd_valid_o & cmd_ready_i. No new command is accepted in that same cycle; the earliest re-acceptance is the next IDLE evaluation.
- rsp_valid_i: rsp_q<=rsp_data_i and rsp_pending<=1. If rsp_valid_i coincides with an adr-0 read, the read returns the old value and rsp_pending stays 1.
- TX pop on tx_valid_o & tx_ready_i.
- RX push on rx_valid_i & rx_ready_o. Pushes with rx_ready_o=0 are dropped.
- Simultaneous push and pop is legal in each FIFO. Full and empty decisions use registered flags only, with no bypass: a full FIFO refuses a push even if it is popped in the same cycle.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full and empty are decided by the MSB compare.

Decomposition:
- Package sd_wb_pkg holds ADR_CMD=1'b0, ADR_DATA=1'b1, the FSM state encodings (IDLE, ACK), and the status-word field positions (bit 63 cmd_pending, bit 62 rsp_pending, bits 47:0 rsp).
- One sub-module, sd_wb_fifo: synchronous FIFO with parameters DEPTH and WIDTH and ports push, pop, din, dout, full, empty. It is instantiated twice, for TX and RX.

Test Plan:
- Reset mid-ACK: assert reset while ack_o=1 -> ack_o=0, tx_valid_o=0 and cmd_valid_o=0 immediately, with no clock edge needed.
- Command handshake: write adr0 data 64'h0000_0000_0000_0011 with cmd_ready_i=0 -> ack after 1 cycle and cmd_valid_o=1. A second adr-0 write stalls with no ack. Raise cmd_ready_i -> cmd_valid_o drops, and the second write is acked 1 cycle after the next IDLE evaluation.
- TX full: strobe held high, we=1, adr=1, data incrementing 1..5, tx_ready_i=0 -> 4 acks, then stall. Pop 1 word (tx_data_o=1) -> the 5th write is acked and tx_data_o sequence is 2,3,4,5.
- RX empty/read: a read of adr1 with RX empty stalls. Push 64'hA5 via rx_valid_i -> ack with wb_data_o=64'hA5. Push 4 words -> rx_ready_o=0, and a 5th push is dropped.
- Status: pulse rsp_valid_i with 48'h1234_5678_9ABC, then read adr0 -> wb_data_o=64'h4000_1234_5678_9ABC. A second read -> 64'h0000_1234_5678_9ABC.
- Coincident response: rsp_valid_i in the same cycle as the adr-0 read accept -> the read returns the old rsp, and the next read shows bit 62=1 with the new rsp.
